// File: rtl/mux_arb_reg.sv
// Registered N-to-1 mux with valid/ready handshakes, fixed-select or round-robin grant.
// Optional MUX_ARB_STATS_EN adds a 16-bit completed-transfer counter port xfer_count.
module mux_arb_reg #(
  parameter int WIDTH    = 16,
  parameter int SEL_BITS = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           mode,
  input  logic [SEL_BITS-1:0]            sel,
  input  logic [(2**SEL_BITS)*WIDTH-1:0] in_data,
  input  logic [(2**SEL_BITS)-1:0]       in_valid,
  output logic [(2**SEL_BITS)-1:0]       in_ready,
  output logic [WIDTH-1:0]               out_data,
  output logic [SEL_BITS-1:0]            out_chan,
  output logic                           out_valid,
  input  logic                           out_ready
`ifdef MUX_ARB_STATS_EN
  ,
  output logic [15:0]                    xfer_count
`endif
);

  localparam int N = 2**SEL_BITS;

  logic [SEL_BITS-1:0] ptr;
  logic [SEL_BITS-1:0] gidx;
  logic [SEL_BITS-1:0] cand;
  logic [N-1:0]        grant;
  logic                found;
  logic                can_load;
  logic                accept;

  assign can_load = !out_valid || out_ready;
  assign in_ready = grant & {N{can_load}};
  assign accept   = found && can_load;

  // grant decision: fixed sel, or first valid channel after ptr (wrapping)
  always_comb begin
    grant = '0;
    gidx  = '0;
    cand  = '0;
    found = 1'b0;
    if (!mode) begin
      gidx = sel;
      if (in_valid[sel]) begin
        grant[sel] = 1'b1;
        found      = 1'b1;
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        cand = ptr + SEL_BITS'(k);
        if (!found && in_valid[cand]) begin
          found       = 1'b1;
          gidx        = cand;
          grant[cand] = 1'b1;
        end
      end
    end
  end

  // one-entry output register and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= '1;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= in_data[gidx*WIDTH +: WIDTH];
      out_chan  <= gidx;
      if (mode) begin
        ptr <= gidx;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef MUX_ARB_STATS_EN
  // count words taken by the consumer, wrapping at 16 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_count <= '0;
    end else if (out_valid && out_ready) begin
      xfer_count <= xfer_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mux_arb_reg.sv
// Directed self-checking bench for mux_arb_reg (WIDTH=16, SEL_BITS=2).
// Expected values are hand-derived from the channel words and grant rules.
module tb_mux_arb_reg;

  logic        clk;
  logic        rst_n;
  logic        mode;
  logic [1:0]  sel;
  logic [63:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [15:0] out_data;
  logic [1:0]  out_chan;
  logic        out_valid;
  logic        out_ready;
`ifdef MUX_ARB_STATS_EN
  logic [15:0] xfer_count;
`endif

  int total;
  int fails;

  logic [15:0] words [4];
  logic [1:0]  alt   [4];
  logic [3:0]  alt_rdy [4];

  mux_arb_reg #(.WIDTH(16), .SEL_BITS(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef MUX_ARB_STATS_EN
    ,
    .xfer_count(xfer_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    fails = 0;
    words[0] = 16'h1234;
    words[1] = 16'hACAC;
    words[2] = 16'h0F0F;
    words[3] = 16'h5554;
    alt[0] = 2'd0; alt[1] = 2'd2; alt[2] = 2'd0; alt[3] = 2'd2;
    alt_rdy[0] = 4'b0001; alt_rdy[1] = 4'b0100;
    alt_rdy[2] = 4'b0001; alt_rdy[3] = 4'b0100;
    in_data   = {16'h5554, 16'h0F0F, 16'hACAC, 16'h1234};
    rst_n     = 1'b0;
    mode      = 1'b0;
    sel       = 2'd0;
    in_valid  = 4'h0;
    out_ready = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'h0);
    chk("rst_chan", 32'(out_chan), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
`ifdef MUX_ARB_STATS_EN
    chk("rst_count", 32'(xfer_count), 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // fixed select, sel=1, all valid
    mode = 1'b0; sel = 2'd1; in_valid = 4'hF; out_ready = 1'b1;
    #1;
    chk("t1_in_ready", 32'(in_ready), 32'b0010);
    tick();
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_data", 32'(out_data), 32'hACAC);
    chk("t1_chan", 32'(out_chan), 32'd1);

    // step sel 0..3
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      sel = 2'(s);
      tick();
      chk("t2_valid", 32'(out_valid), 32'd1);
      chk("t2_data", 32'(out_data), 32'(words[s]));
      chk("t2_chan", 32'(out_chan), 32'(s));
    end

    // reset then round-robin over all channels
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t3_rst_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t3_valid", 32'(out_valid), 32'd1);
      chk("t3_chan", 32'(out_chan), 32'(i % 4));
      chk("t3_data", 32'(out_data), 32'(words[i % 4]));
    end

    // round-robin with only ch0 and ch2 valid
    @(negedge clk);
    in_valid = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t4_in_ready", 32'(in_ready), 32'(alt_rdy[i]));
      tick();
      chk("t4_chan", 32'(out_chan), 32'(alt[i]));
    end

    // backpressure with ACAC held
    @(negedge clk);
    mode = 1'b0; sel = 2'd1; in_valid = 4'hF;
    tick();
    chk("t5_load_data", 32'(out_data), 32'hACAC);
    @(negedge clk);
    out_ready = 1'b0; sel = 2'd3;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t5_bp_ready", 32'(in_ready), 32'h0);
      tick();
      chk("t5_bp_data", 32'(out_data), 32'hACAC);
      chk("t5_bp_chan", 32'(out_chan), 32'd1);
      chk("t5_bp_valid", 32'(out_valid), 32'd1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("t5_rel_ready", 32'(in_ready), 32'b1000);
    tick();
    chk("t5_next_data", 32'(out_data), 32'h5554);
    chk("t5_next_chan", 32'(out_chan), 32'd3);
    chk("t5_next_valid", 32'(out_valid), 32'd1);

    // selected channel idle: other valid waits, output drains
    @(negedge clk);
    sel = 2'd2; in_valid = 4'b0001;
    #1;
    chk("wait_ready", 32'(in_ready), 32'h0);
    tick();
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_data", 32'(out_data), 32'h5554);
    chk("drain_chan", 32'(out_chan), 32'd3);

    // ptr kept through fixed mode: last rr grant was ch2, so ch3 next
    @(negedge clk);
    mode = 1'b1; in_valid = 4'hF;
    tick();
    chk("t6_ptr_kept", 32'(out_chan), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_data", 32'(out_data), 32'h0);
`ifdef MUX_ARB_STATS_EN
    chk("t6_rst_count", 32'(xfer_count), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t6_in_ready", 32'(in_ready), 32'b0001);
    tick();
    chk("t6_chan", 32'(out_chan), 32'd0);
    chk("t6_data", 32'(out_data), 32'h1234);
`ifdef MUX_ARB_STATS_EN
    chk("t6_count0", 32'(xfer_count), 32'd0);
    tick();
    chk("t6_count1", 32'(xfer_count), 32'd1);
`endif

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
